// File: rtl/d5m_bayer_emitter.sv
// Mosaics an 8-bit RGB pixel stream into 12-bit D5M-style Bayer raw samples with
// camera-style FVAL/LVAL/DVAL framing and X/Y counters; every output is registered.
module d5m_bayer_emitter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  input  logic        iPIX_VALID,
  output logic        oPIX_READY,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic        oLVAL,
  output logic        oFVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic        oFRAME_DONE,
  output logic        oUNDERRUN
);

  localparam int LINE_CYC = H_ACTIVE + H_BLANK;
  localparam int VB_CYC   = V_BLANK * LINE_CYC;
  localparam int CW       = $clog2(VB_CYC + 1);
  localparam logic [CW-1:0] VB_LAST   = CW'(VB_CYC - 1);
  localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
  localparam logic [10:0]   COL_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   LINE_LAST = 11'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} state_t;

  state_t        stateReg, stateNext;
  logic [CW-1:0] blankCnt, blankCntNext;
  logic [10:0]   colReg, colNext;
  logic [10:0]   lineReg, lineNext;
  logic          active, frameEnd, fvalNext;
  logic [7:0]    comp;
  logic [11:0]   sample;

  assign active     = (stateReg == ACTIVE);
  assign frameEnd   = (stateReg == HBLANK) && (blankCnt == HB_LAST) && (lineReg == LINE_LAST);
  // Frame valid covers the last line's trailing blank but drops with the done pulse.
  assign fvalNext   = active || ((stateReg == HBLANK) && !frameEnd);
  assign oPIX_READY = active;

  always_comb begin
    case ({lineReg[0], colReg[0]})
      2'b01:   comp = iR;
      2'b10:   comp = iB;
      default: comp = iG;
    endcase
  end

  assign sample = {comp, comp[7:4]};

  always_comb begin
    stateNext    = stateReg;
    blankCntNext = blankCnt;
    colNext      = colReg;
    lineNext     = lineReg;
    case (stateReg)
      IDLE: begin
        if (iEN) begin
          stateNext    = VBLANK;
          blankCntNext = '0;
        end
      end
      VBLANK: begin
        if (blankCnt == VB_LAST) begin
          stateNext    = ACTIVE;
          blankCntNext = '0;
          colNext      = '0;
          lineNext     = '0;
        end else begin
          blankCntNext = blankCnt + CW'(1);
        end
      end
      ACTIVE: begin
        if (colReg == COL_LAST) begin
          stateNext    = HBLANK;
          colNext      = '0;
          blankCntNext = '0;
        end else begin
          colNext = colReg + 11'd1;
        end
      end
      HBLANK: begin
        if (blankCnt == HB_LAST) begin
          blankCntNext = '0;
          if (lineReg != LINE_LAST) begin
            stateNext = ACTIVE;
            lineNext  = lineReg + 11'd1;
          end else begin
            stateNext = iEN ? VBLANK : IDLE;
            lineNext  = '0;
          end
        end else begin
          blankCntNext = blankCnt + CW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      stateReg <= IDLE;
      blankCnt <= '0;
      colReg   <= '0;
      lineReg  <= '0;
    end else begin
      stateReg <= stateNext;
      blankCnt <= blankCntNext;
      colReg   <= colNext;
      lineReg  <= lineNext;
    end
  end

  // The sensor cannot stall: a missing pixel still produces a (zero) sample.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oLVAL       <= 1'b0;
      oFVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFRAME_DONE <= 1'b0;
      oUNDERRUN   <= 1'b0;
    end else begin
      oDATA       <= (active && iPIX_VALID) ? sample : 12'h000;
      oDVAL       <= active;
      oLVAL       <= active;
      oFVAL       <= fvalNext;
      oX_Cont     <= active ? colReg : 11'd0;
      oFRAME_DONE <= frameEnd;
      if (active) begin
        oY_Cont <= lineReg;
      end
      if (active && !iPIX_VALID) begin
        oUNDERRUN <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_d5m_bayer_emitter.sv
// Scoreboard bench for d5m_bayer_emitter: a source driver pushes expected samples from a
// position-based Bayer model; a monitor pops and compares whenever oDVAL is high.
module tb_d5m_bayer_emitter;

  localparam int HA = 4;
  localparam int VA = 2;
  localparam int HB = 2;
  localparam int VB = 1;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iEN = 1'b0;
  logic [7:0]  iR, iG, iB;
  logic        iPIX_VALID;
  logic        oPIX_READY;
  logic [11:0] oDATA;
  logic        oDVAL, oLVAL, oFVAL;
  logic [10:0] oX_Cont, oY_Cont;
  logic        oFRAME_DONE, oUNDERRUN;

  d5m_bayer_emitter #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN),
    .iR(iR), .iG(iG), .iB(iB), .iPIX_VALID(iPIX_VALID),
    .oPIX_READY(oPIX_READY), .oDATA(oDATA), .oDVAL(oDVAL), .oLVAL(oLVAL), .oFVAL(oFVAL),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFRAME_DONE(oFRAME_DONE), .oUNDERRUN(oUNDERRUN)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int d;
    int x;
    int y;
    int u;
  } exp_t;

  exp_t expQ[$];
  int   passCnt = 0;
  int   totalCnt = 0;
  int   pixIdx = 0;
  int   sampCnt = 0;
  bit   expUnder = 1'b0;
  bit   fixedPix = 1'b1;
  bit   randDrop = 1'b0;
  int   dropIdx = -1;

  task automatic chk(input string name, input int act, input int req);
    totalCnt++;
    if (act == req) passCnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
  endtask

  // Source driver and reference model: expected sample depends only on stream position.
  always @(negedge iCLK) begin
    if (!iRST) begin
      pixIdx     = 0;
      expUnder   = 1'b0;
      iPIX_VALID = 1'b0;
      iR = 8'h00; iG = 8'h00; iB = 8'h00;
    end else if (oPIX_READY) begin
      int   row, col, c;
      bit   v;
      exp_t e;
      if (fixedPix) begin
        iR = 8'h10; iG = 8'h80; iB = 8'hFF;
      end else begin
        iR = 8'($urandom); iG = 8'($urandom); iB = 8'($urandom);
      end
      v = !((pixIdx == dropIdx) || (randDrop && ($urandom_range(0, 7) == 0)));
      iPIX_VALID = v;
      col = pixIdx % HA;
      row = (pixIdx / HA) % VA;
      if (row % 2 == 0 && col % 2 == 1)      c = int'(iR);
      else if (row % 2 == 1 && col % 2 == 0) c = int'(iB);
      else                                   c = int'(iG);
      if (!v) expUnder = 1'b1;
      e.d = v ? (c * 16 + c / 16) : 0;
      e.x = col;
      e.y = row;
      e.u = int'(expUnder);
      expQ.push_back(e);
      pixIdx++;
    end else begin
      iPIX_VALID = 1'($urandom_range(0, 1));
      iR = 8'($urandom); iG = 8'($urandom); iB = 8'($urandom);
    end
  end

  // Monitor: compares each emitted sample against the scoreboard, and blanking otherwise.
  always @(negedge iCLK) begin
    if (!iRST) begin
      expQ.delete();
    end else if (oDVAL) begin
      exp_t e;
      sampCnt++;
      $display("sample x=%0d y=%0d data=%03h underrun=%0b", oX_Cont, oY_Cont, oDATA, oUNDERRUN);
      if (expQ.size() == 0) begin
        chk("unexpected_sample", 1, 0);
      end else begin
        e = expQ.pop_front();
        chk("data", int'(oDATA), e.d);
        chk("x_cont", int'(oX_Cont), e.x);
        chk("y_cont", int'(oY_Cont), e.y);
        chk("underrun", int'(oUNDERRUN), e.u);
        chk("lval_in_line", int'(oLVAL), 1);
        chk("fval_in_line", int'(oFVAL), 1);
      end
    end else begin
      chk("blank_data", int'(oDATA), 0);
      chk("blank_x", int'(oX_Cont), 0);
      chk("blank_lval", int'(oLVAL), 0);
    end
  end

  task automatic waitFor(input int sel, input int maxCyc, output int n);
    n = -1;
    for (int i = 1; i <= maxCyc; i++) begin
      @(posedge iCLK);
      #1;
      if ((sel == 0 && oPIX_READY) || (sel == 1 && oFRAME_DONE)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic checkResetVals(input string tag);
    chk({tag, "_data"}, int'(oDATA), 0);
    chk({tag, "_dval"}, int'(oDVAL), 0);
    chk({tag, "_lval"}, int'(oLVAL), 0);
    chk({tag, "_fval"}, int'(oFVAL), 0);
    chk({tag, "_x"}, int'(oX_Cont), 0);
    chk({tag, "_y"}, int'(oY_Cont), 0);
    chk({tag, "_done"}, int'(oFRAME_DONE), 0);
    chk({tag, "_underrun"}, int'(oUNDERRUN), 0);
    chk({tag, "_ready"}, int'(oPIX_READY), 0);
  endtask

  task automatic doReset();
    iRST = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    checkResetVals("reset");
    @(negedge iCLK);
    iRST = 1'b1;
  endtask

  initial begin
    int  n, nDone, cntStart;
    bit  found;

    // Fixed colour, all pixels valid, iEN held for two frames then dropped.
    fixedPix = 1'b1; randDrop = 1'b0; dropIdx = -1;
    doReset();
    iEN = 1'b1;
    waitFor(0, 40, n);
    chk("ready_latency", n, 7);
    cntStart = sampCnt;
    waitFor(1, 40, nDone);
    chk("done_after_vblank_entry", nDone + 6, 18);
    chk("fval_falls_at_done", int'(oFVAL), 0);
    chk("y_holds_in_blank", int'(oY_Cont), 1);
    chk("frame1_samples", sampCnt - cntStart, 8);
    waitFor(0, 40, n);
    chk("vblank_after_done", n, 6);
    chk("frame_period", nDone + n, 18);
    cntStart = sampCnt;
    @(negedge iCLK);
    iEN = 1'b0;
    waitFor(1, 40, n);
    chk("frame2_done_seen", int'(n > 0), 1);
    chk("frame2_samples", sampCnt - cntStart, 8);
    waitFor(0, 30, n);
    chk("ready_stays_low", n, -1);
    chk("queue_drained", expQ.size(), 0);

    // Random colour with a dropped pixel at line 0 col 2, then reset mid-frame.
    fixedPix = 1'b0; dropIdx = 2;
    doReset();
    iEN = 1'b1;
    waitFor(0, 40, n);
    chk("ready_latency_2", n, 7);
    waitFor(1, 40, n);
    chk("underrun_sticky", int'(oUNDERRUN), 1);
    randDrop = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge iCLK);
      #1;
      if (pixIdx == 14) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_line1_col1", int'(found), 1);
    iRST = 1'b0;
    #1;
    checkResetVals("async_reset");
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    dropIdx = -1; randDrop = 1'b0;
    iRST = 1'b1;
    cntStart = sampCnt;
    waitFor(0, 40, n);
    chk("ready_latency_after_reset", n, 7);
    chk("no_sample_before_vblank", sampCnt - cntStart, 0);
    @(negedge iCLK);
    iEN = 1'b0;
    waitFor(1, 40, n);
    chk("frame3_done_seen", int'(n > 0), 1);
    chk("frame3_samples", sampCnt - cntStart, 8);
    chk("underrun_cleared_by_reset", int'(oUNDERRUN), 0);
    @(negedge iCLK);
    #1;
    chk("queue_drained_2", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/d5m_bayer_emitter.md
# d5m_bayer_emitter

Mosaics an 8-bit RGB pixel stream into 12-bit D5M-style Bayer raw data. Emits it with camera-accurate frame, line and data-valid framing plus X/Y counters, so the Bayer-to-greyscale capture path can run in simulation and on hardware without a sensor. The block sits between a frame source (test-pattern generator or DMA reader) and the raw-input port of the capture pipeline. It produces exactly the stream that port consumes.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_BLANK, 16, blank cycles after each active line (≥1)
- V_BLANK, 4, blank line-periods before each frame (≥1); one line-period = H_ACTIVE+H_BLANK cycles
- iCLK  in  1  pixel clock
- iRST  in  1  reset, asynchronous, active-low; clock iCLK
- iEN  in  1  run enable; sampled in IDLE and at frame end
- iR, iG, iB  in  8 each  source pixel components
- iPIX_VALID  in  1  source pixel valid
- oPIX_READY  out  1  block accepts a pixel this cycle
- oDATA  out  12  Bayer raw sample
- oDVAL  out  1  oDATA valid
- oLVAL  out  1  line valid
- oFVAL  out  1  frame valid
- oX_Cont  out  11  column of current sample
- oY_Cont  out  11  row of current sample
- oFRAME_DONE  out  1  one-cycle pulse after last HBLANK of a frame
- oUNDERRUN  out  1  sticky; set on a missed pixel

## Operation
- FSM states: IDLE, VBLANK, ACTIVE, HBLANK.
- IDLE: when iEN=1, go to VBLANK next cycle.
- VBLANK: lasts V_BLANK*(H_ACTIVE+H_BLANK) cycles, then ACTIVE with line=0, col=0.
- ACTIVE: H_ACTIVE cycles, then HBLANK.
- HBLANK: H_BLANK cycles. If line < V_ACTIVE-1: line++, go to ACTIVE. Otherwise pulse oFRAME_DONE, then go to VBLANK if iEN=1, else IDLE.
- iEN falling mid-frame has no effect; the current frame always completes.
- oPIX_READY = 1 exactly in ACTIVE. This is decoded from registered state, never from iPIX_VALID.
- Accept occurs when iPIX_VALID && oPIX_READY.
- The sensor cannot stall. If iPIX_VALID=0 in an ACTIVE cycle:
  - the sample is emitted as 12'h000 with oDVAL=1;
  - oUNDERRUN is set;
  - col still advances.
- oUNDERRUN clears only on reset.
- Bayer pattern, indexed by {row[0], col[0]}:
  - 00 → G
  - 01 → R
  - 10 → B
  - 11 → G
- Component expansion to 12 bits: {c[7:0], c[7:4]}. Examples: 8'hFF→12'hFFF, 8'h80→12'h808, 8'h00→12'h000.
- Counters are 11-bit:
  - col wraps to 0 at H_ACTIVE;
  - line wraps to 0 at frame end;
  - parameters > 2047 are illegal.

## Timing
- All outputs are registered, with one cycle of latency from the ACTIVE cycle to the outputs.
- A pixel accepted in cycle t appears in cycle t+1 on oDATA, with oDVAL=1, oLVAL=1, oX_Cont=col and oY_Cont=line.
- oLVAL equals oDVAL.
- oFVAL rises together with oDVAL for col 0 of line 0. It stays high through the delayed HBLANK of line V_ACTIVE-1 and falls in the cycle oFRAME_DONE pulses.
- During blanking:
  - oDATA = 0 and oDVAL = 0;
  - oX_Cont = 0;
  - oY_Cont holds the last line index.
- Reset values: oDATA=0, oDVAL=0, oLVAL=0, oFVAL=0, oX_Cont=0, oY_Cont=0, oFRAME_DONE=0, oUNDERRUN=0, oPIX_READY=0, state=IDLE.
- Reset asserted mid-frame forces all of the above immediately. No partial line is emitted after release; the block restarts from IDLE.
- Frame period: (V_BLANK+V_ACTIVE)*(H_ACTIVE+H_BLANK) cycles. With iEN held high, back-to-back frames have no extra gap.

## Test plan
Bench parameters: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=1.

- Reset, then iEN=1 with iPIX_VALID always 1:
  - oPIX_READY first rises 7 cycles after the cycle iEN is sampled (1 IDLE cycle + 6 VBLANK cycles);
  - oDVAL shows 4-high/2-low twice;
  - oFRAME_DONE pulses once, 18 cycles after VBLANK entry.
- Pixel RGB=(8'h10, 8'h80, 8'hFF) on every cycle:
  - line 0 oDATA = 808, 101, 808, 101;
  - line 1 oDATA = FFF, 808, FFF, 808;
  - oX_Cont = 0..3; oY_Cont = 0, then 1.
- iPIX_VALID=0 for col 2 of line 0:
  - that sample is 12'h000 with oDVAL=1;
  - oUNDERRUN goes 1 and stays 1;
  - col 3 is emitted normally from the next pixel.
- iEN dropped during line 0:
  - frame completes with all 8 samples;
  - FSM returns to IDLE;
  - oPIX_READY stays 0 afterwards.
- iEN held high:
  - the second frame's VBLANK starts the cycle after oFRAME_DONE;
  - total period is 18 cycles.
- iRST low during line 1 col 1:
  - all outputs go to reset values asynchronously;
  - after release with iEN=1, a full 6-cycle VBLANK precedes the next sample.
